// File: rtl/uart_tx.sv
// UART transmitter: VALID/READY byte in, async serial frame out on TX.
// Frame: start bit, LSB-first data, optional parity bit, one stop bit.
module uart_tx #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [DATA_BITS-1:0] DATA_IN,
    input  logic                 VALID,
    output logic                 READY,
    output logic                 TX,
    output logic                 BUSY
);

    localparam int CW = $clog2(DATA_BITS + 1);
    localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_BITS - 1);
    localparam logic          ODD      = (PARITY_ODD != 0);
    localparam logic          PAR_ON   = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [DW-1:0]        div_q, div_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 bit_end;

    assign bit_end = (div_q == DIV_LAST);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = '0;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        ready_d = ready_q;

        // Divider free-runs through every non-idle bit and wraps on bit_end.
        if (state_q != IDLE && !bit_end) begin
            div_d = div_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                if (VALID) begin
                    shift_d = DATA_IN;
                    par_d   = (^DATA_IN) ^ ODD;
                    cnt_d   = '0;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (cnt_q == CNT_LAST) begin
                        if (PAR_ON) begin
                            tx_d    = par_q;
                            state_d = PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        tx_d  = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign TX    = tx_q;
    assign READY = ready_q;
    assign BUSY  = ~ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: four parameterisations share one clock,
// each with its own expected-frame queue and monitor.
module tb_uart_tx;

    localparam int NDUT = 4;

    typedef struct packed {
        logic [11:0] seq;
        logic [3:0]  nbits;
        logic        chk_gap;
        logic        abort;
    } frame_t;

    function automatic int cpb_of(input int g);
        return (g == 3) ? 1 : 4;
    endfunction

    function automatic int pen_of(input int g);
        return (g == 1 || g == 2) ? 1 : 0;
    endfunction

    function automatic int podd_of(input int g);
        return (g == 2) ? 1 : 0;
    endfunction

    logic       CLK;
    logic       rst   [NDUT];
    logic       valid [NDUT];
    logic [7:0] din   [NDUT];
    logic       ready [NDUT];
    logic       tx    [NDUT];
    logic       busy  [NDUT];

    frame_t exp_q [NDUT][$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int g,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h",
                     nm, g, $time, act, exp);
        end
    endtask

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        uart_tx #(
            .DATA_BITS   (8),
            .CLKS_PER_BIT(cpb_of(g)),
            .PARITY_EN   (pen_of(g)),
            .PARITY_ODD  (podd_of(g))
        ) dut (
            .CLK    (CLK),
            .RESET  (rst[g]),
            .DATA_IN(din[g]),
            .VALID  (valid[g]),
            .READY  (ready[g]),
            .TX     (tx[g]),
            .BUSY   (busy[g])
        );

        localparam int C = cpb_of(g);

        initial begin : mon
            frame_t cur;
            bit     active;
            int     k;
            int     idle;
            active = 1'b0;
            k      = 0;
            idle   = 0;
            cur    = '0;
            forever begin
                @(negedge CLK);
                if (rst[g]) begin
                    if (active) chk("abort_expected", g, cur.abort, 1);
                    active = 1'b0;
                    idle   = 0;
                end else begin
                    if (!active) begin
                        if (!ready[g]) begin
                            chk("frame_expected", g,
                                32'(exp_q[g].size() != 0), 1);
                            if (exp_q[g].size() != 0) begin
                                cur    = exp_q[g].pop_front();
                                active = 1'b1;
                                k      = 0;
                                if (cur.chk_gap) chk("idle_gap", g, idle, 1);
                            end
                        end else begin
                            chk("idle_tx", g, tx[g], 1);
                            idle++;
                        end
                    end
                    if (active) begin
                        if (k < int'(cur.nbits) * C) begin
                            chk("tx_bit", g, tx[g], cur.seq[k / C]);
                            chk("busy", g, busy[g], 1);
                            k++;
                        end else begin
                            chk("ready_at_end", g, ready[g], 1);
                            chk("stop_idle_tx", g, tx[g], 1);
                            active = 1'b0;
                            idle   = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic push(input int g, input logic [11:0] seq, input int nb,
                        input bit gap, input bit ab);
        frame_t f;
        f.seq     = seq;
        f.nbits   = 4'(nb);
        f.chk_gap = gap;
        f.abort   = ab;
        exp_q[g].push_back(f);
    endtask

    task automatic wait_ready(input int g);
        int t;
        t = 0;
        while (!ready[g] && t < 200) begin
            @(posedge CLK);
            #1;
            t++;
        end
        chk("ready_in_time", g, ready[g], 1);
    endtask

    task automatic send(input int g, input logic [7:0] d,
                        input logic [11:0] seq, input int nb, input bit ab);
        wait_ready(g);
        push(g, seq, nb, 1'b0, ab);
        din[g]   = d;
        valid[g] = 1'b1;
        @(posedge CLK);
        #1;
        valid[g] = 1'b0;
        din[g]   = ~d;
    endtask

    task automatic rst_pulse(input int g, input int hold);
        @(posedge CLK);
        #2;
        rst[g] = 1'b1;
        #1;
        chk("rst_tx", g, tx[g], 1);
        chk("rst_ready", g, ready[g], 1);
        chk("rst_busy", g, busy[g], 0);
        repeat (hold) @(posedge CLK);
        #2;
        rst[g] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            rst[i]   = 1'b1;
            valid[i] = 1'b0;
            din[i]   = 8'h00;
        end
        #2;
        for (int i = 0; i < NDUT; i++) begin
            chk("por_tx", i, tx[i], 1);
            chk("por_ready", i, ready[i], 1);
            chk("por_busy", i, busy[i], 0);
        end
        @(posedge CLK);
        #2;
        for (int i = 0; i < NDUT; i++) rst[i] = 1'b0;

        repeat (20) @(posedge CLK);
        rst_pulse(0, 2);
        repeat (20) @(posedge CLK);
        #1;

        send(0, 8'hA5, {1'b1, 8'hA5, 1'b0}, 10, 1'b0);
        send(1, 8'h07, {1'b1, 1'b1, 8'h07, 1'b0}, 11, 1'b0);
        send(2, 8'h07, {1'b1, 1'b0, 8'h07, 1'b0}, 11, 1'b0);
        send(3, 8'h55, {1'b1, 8'h55, 1'b0}, 10, 1'b0);
        wait_ready(0);
        wait_ready(1);
        wait_ready(2);
        wait_ready(3);
        repeat (3) @(posedge CLK);
        #1;

        // Back-to-back with VALID held; DATA_IN wiggles mid-frame.
        push(0, {1'b1, 8'h00, 1'b0}, 10, 1'b0, 1'b0);
        push(0, {1'b1, 8'hFF, 1'b0}, 10, 1'b1, 1'b0);
        din[0]   = 8'h00;
        valid[0] = 1'b1;
        @(posedge CLK);
        #1;
        din[0] = 8'h5A;
        repeat (20) @(posedge CLK);
        #1;
        din[0] = 8'hFF;
        wait_ready(0);
        @(posedge CLK);
        #1;
        chk("b2b_second_handshake", 0, ready[0], 0);
        valid[0] = 1'b0;
        din[0]   = 8'h33;
        repeat (10) @(posedge CLK);
        #1;
        valid[0] = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        valid[0] = 1'b0;
        wait_ready(0);
        repeat (3) @(posedge CLK);
        #1;

        // Abort 8'h3C during its 4th data bit, then send 8'h81.
        send(0, 8'h3C, {1'b1, 8'h3C, 1'b0}, 10, 1'b1);
        repeat (16) @(posedge CLK);
        #1;
        chk("pre_abort_busy", 0, busy[0], 1);
        rst_pulse(0, 1);
        repeat (2) @(posedge CLK);
        #1;
        send(0, 8'h81, {1'b1, 8'h81, 1'b0}, 10, 1'b0);
        send(3, 8'hC3, {1'b1, 8'hC3, 1'b0}, 10, 1'b0);
        wait_ready(0);
        wait_ready(3);
        repeat (5) @(posedge CLK);
        #1;

        for (int i = 0; i < NDUT; i++) begin
            chk("queue_drained", i, exp_q[i].size(), 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
